// File: rtl/jk_reg_array_if.sv
// Control/data bundle for jk_reg_array: mode selection, per-bit JK and load inputs, state outputs.
interface jk_reg_array_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;

  modport master (
    output en, mode, j, k, d,
    input  q, qbar, tc, wrap
  );

  modport slave (
    input  en, mode, j, k, d,
    output q, qbar, tc, wrap
  );
endinterface

// File: rtl/jk_reg_array.sv
// WIDTH-bit bank of JK storage elements that also acts as an up/down counter or load register.
module jk_reg_array #(
  parameter int unsigned WIDTH     = 4,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input logic          clk,
  input logic          reset,
  jk_reg_array_if.slave jk
);

  localparam logic [1:0] ModeJk   = 2'b00;
  localparam logic [1:0] ModeUp   = 2'b01;
  localparam logic [1:0] ModeDown = 2'b10;
  localparam logic [1:0] ModeLoad = 2'b11;

  localparam logic [WIDTH-1:0] ResetQ = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q;
  logic             tc;

  always_comb begin
    q_d = q_q;
    unique case (jk.mode)
      ModeJk:   q_d = (jk.j & ~q_q) | (~jk.k & q_q);
      ModeUp:   q_d = q_q + One;
      ModeDown: q_d = q_q - One;
      ModeLoad: q_d = jk.d;
      default:  q_d = q_q;
    endcase
  end

  // Terminal count only in counting modes, so loads and JK passes through wrap values never pulse.
  always_comb begin
    tc = 1'b0;
    if (jk.en) begin
      tc = ((jk.mode == ModeUp) && (&q_q)) || ((jk.mode == ModeDown) && !(|q_q));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= ResetQ;
      wrap_q <= 1'b0;
    end else if (!jk.en) begin
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= tc;
    end
  end

  assign jk.q    = q_q;
  assign jk.qbar = ~q_q;
  assign jk.tc   = tc;
  assign jk.wrap = wrap_q;

endmodule

// File: tb/tb_jk_reg_array.sv
// Directed self-checking bench for jk_reg_array at WIDTH 4, 1 and 8.
module tb_jk_reg_array;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  jk_reg_array_if #(.WIDTH(4)) bus_a ();
  jk_reg_array_if #(.WIDTH(1)) bus_b ();
  jk_reg_array_if #(.WIDTH(8)) bus_c ();

  jk_reg_array #(.WIDTH(4), .RESET_VAL(32'd0)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .jk    (bus_a)
  );

  jk_reg_array #(.WIDTH(1), .RESET_VAL(32'd0)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .jk    (bus_b)
  );

  jk_reg_array #(.WIDTH(8), .RESET_VAL(32'hA5)) dut_c (
    .clk   (clk),
    .reset (rst_c),
    .jk    (bus_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic en, input logic [1:0] mode, input logic [3:0] j,
                         input logic [3:0] k, input logic [3:0] d);
    bus_a.en   = en;
    bus_a.mode = mode;
    bus_a.j    = j;
    bus_a.k    = k;
    bus_a.d    = d;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    drive_a(1'b1, 2'b01, 4'hF, 4'h3, 4'hC);
    bus_b.en = 1'b0; bus_b.mode = 2'b01; bus_b.j = 1'b1; bus_b.k = 1'b0; bus_b.d = 1'b1;
    bus_c.en = 1'b0; bus_c.mode = 2'b11; bus_c.j = 8'h00; bus_c.k = 8'hFF; bus_c.d = 8'h3C;
    tick();
    chk("rst_q", 32'(bus_a.q), 32'h0);
    chk("rst_qbar", 32'(bus_a.qbar), 32'hF);
    chk("rst_wrap", 32'(bus_a.wrap), 32'h0);
    chk("w8_rst_q", 32'(bus_c.q), 32'hA5);
    chk("w8_rst_qbar", 32'(bus_c.qbar), 32'h5A);
    rst_b = 1'b0;
    rst_c = 1'b0;

    // Releasing reset and changing inputs between edges must not move Q.
    rst_a = 1'b0;
    drive_a(1'b1, 2'b11, 4'h0, 4'h0, 4'h5);
    #3;
    chk("sync_hold", 32'(bus_a.q), 32'h0);
    tick();
    chk("load_0101", 32'(bus_a.q), 32'h5);

    drive_a(1'b1, 2'b00, 4'h0, 4'h0, 4'hA);
    tick();
    chk("jk_hold", 32'(bus_a.q), 32'h5);
    drive_a(1'b1, 2'b00, 4'hA, 4'h0, 4'h0);
    tick();
    chk("jk_set", 32'(bus_a.q), 32'hF);
    chk("jk_tc0", 32'(bus_a.tc), 32'h0);
    drive_a(1'b1, 2'b00, 4'h0, 4'h3, 4'hF);
    tick();
    chk("jk_clear", 32'(bus_a.q), 32'hC);
    chk("jk_nowrap", 32'(bus_a.wrap), 32'h0);
    drive_a(1'b1, 2'b00, 4'hF, 4'hF, 4'h0);
    tick();
    chk("jk_toggle", 32'(bus_a.q), 32'h3);

    // Up-count wrap from zero.
    rst_a = 1'b1;
    drive_a(1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    tick();
    rst_a = 1'b0;
    chk("up_start", 32'(bus_a.q), 32'h0);
    for (int i = 0; i < 15; i++) tick();
    chk("up_15", 32'(bus_a.q), 32'hF);
    chk("up_tc", 32'(bus_a.tc), 32'h1);
    chk("up_wrap_pre", 32'(bus_a.wrap), 32'h0);
    tick();
    chk("up_wrapped_q", 32'(bus_a.q), 32'h0);
    chk("up_wrap", 32'(bus_a.wrap), 32'h1);
    chk("up_tc_after", 32'(bus_a.tc), 32'h0);
    tick();
    chk("up_q1", 32'(bus_a.q), 32'h1);
    chk("up_wrap_once", 32'(bus_a.wrap), 32'h0);

    // Load then count down through zero.
    drive_a(1'b1, 2'b11, 4'hF, 4'hF, 4'h2);
    tick();
    chk("dn_load", 32'(bus_a.q), 32'h2);
    chk("dn_load_wrap", 32'(bus_a.wrap), 32'h0);
    drive_a(1'b1, 2'b10, 4'hF, 4'h0, 4'h9);
    tick();
    chk("dn_1", 32'(bus_a.q), 32'h1);
    chk("dn_tc0", 32'(bus_a.tc), 32'h0);
    tick();
    chk("dn_0", 32'(bus_a.q), 32'h0);
    chk("dn_tc1", 32'(bus_a.tc), 32'h1);
    tick();
    chk("dn_f", 32'(bus_a.q), 32'hF);
    chk("dn_wrap", 32'(bus_a.wrap), 32'h1);
    tick();
    chk("dn_e", 32'(bus_a.q), 32'hE);
    chk("dn_wrap_once", 32'(bus_a.wrap), 32'h0);

    // Loading across a wrap value produces no pulse.
    drive_a(1'b1, 2'b11, 4'h0, 4'h0, 4'hF);
    tick();
    drive_a(1'b1, 2'b11, 4'h0, 4'h0, 4'h0);
    tick();
    chk("load_wrap_q", 32'(bus_a.q), 32'h0);
    chk("load_no_wrap", 32'(bus_a.wrap), 32'h0);

    // Enable low holds and masks TC.
    drive_a(1'b1, 2'b11, 4'h0, 4'h0, 4'hF);
    tick();
    drive_a(1'b0, 2'b01, 4'hF, 4'hF, 4'h0);
    #1;
    chk("en0_tc", 32'(bus_a.tc), 32'h0);
    tick();
    chk("en0_hold", 32'(bus_a.q), 32'hF);
    chk("en0_wrap", 32'(bus_a.wrap), 32'h0);

    // Reset beats a pending wrap.
    drive_a(1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    #1;
    chk("pri_tc", 32'(bus_a.tc), 32'h1);
    rst_a = 1'b1;
    tick();
    chk("pri_q", 32'(bus_a.q), 32'h0);
    chk("pri_wrap", 32'(bus_a.wrap), 32'h0);
    rst_a = 1'b0;

    // Reset acts with enable low.
    drive_a(1'b1, 2'b11, 4'h0, 4'h0, 4'h7);
    tick();
    drive_a(1'b0, 2'b11, 4'h0, 4'h0, 4'h9);
    rst_a = 1'b1;
    tick();
    chk("rst_en0", 32'(bus_a.q), 32'h0);
    rst_a = 1'b0;

    // WIDTH = 1 toggles when counting.
    bus_b.en = 1'b1;
    bus_b.mode = 2'b01;
    #1;
    chk("w1_tc0", 32'(bus_b.tc), 32'h0);
    tick();
    chk("w1_q1", 32'(bus_b.q), 32'h1);
    chk("w1_wrap0", 32'(bus_b.wrap), 32'h0);
    chk("w1_tc1", 32'(bus_b.tc), 32'h1);
    tick();
    chk("w1_q0", 32'(bus_b.q), 32'h0);
    chk("w1_wrap1", 32'(bus_b.wrap), 32'h1);
    tick();
    chk("w1_q1b", 32'(bus_b.q), 32'h1);
    chk("w1_wrap0b", 32'(bus_b.wrap), 32'h0);
    tick();
    chk("w1_wrap1b", 32'(bus_b.wrap), 32'h1);
    bus_b.mode = 2'b10;
    #1;
    chk("w1_dn_tc", 32'(bus_b.tc), 32'h1);
    tick();
    chk("w1_dn_q", 32'(bus_b.q), 32'h1);
    chk("w8_hold", 32'(bus_c.q), 32'hA5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_reg_array.md
Name: jk_reg_array

Overview:
- Parametrised successor to the single JK flip-flop: a WIDTH-bit bank of JK-style storage elements sharing one clock and reset.
- The bank also works as a synchronous up/down counter or a parallel-load register, selected by a 2-bit mode input.
- Intended as the reusable sequential primitive for later lab datapaths (counters, shift/toggle registers). It replaces per-bit JK instances.

Parameters:
- WIDTH, 4, number of flip-flops in the bank (legal range 1..32).
- RESET_VAL, 0, value loaded into Q on Reset (WIDTH bits, zero-extended/truncated to WIDTH).

Ports:
- Clk     input   1      clock; all state changes on rising edge.
- Reset   input   1      synchronous, active-high reset; highest priority.
- En      input   1      clock enable; 0 = hold all state.
- Mode    input   2      00 = per-bit JK, 01 = count up, 10 = count down, 11 = parallel load.
- J       input   WIDTH  per-bit J inputs (used in Mode 00 only).
- K       input   WIDTH  per-bit K inputs (used in Mode 00 only).
- D       input   WIDTH  parallel load data (used in Mode 11 only).
- Q       output  WIDTH  registered state.
- Qbar    output  WIDTH  bitwise complement of Q, always equal to ~Q (combinational).
- TC      output  1      terminal count, combinational.
- Wrap    output  1      registered one-cycle pulse after a counter wrap.

Behaviour:
- Reset is synchronous and active-high, sampled at the rising edge of Clk; no asynchronous path.
- Reset outputs: Q = RESET_VAL, Qbar = ~RESET_VAL, Wrap = 0. TC follows its equation from the reset Q.
- Priority at each rising edge: Reset > En = 0 > Mode.
- En = 0, Reset = 0: Q holds, Wrap <= 0.
- Mode 00 (JK), per bit i, next Q[i]:
  - J = 0, K = 0: hold.
  - J = 0, K = 1: 0.
  - J = 1, K = 0: 1.
  - J = 1, K = 1: toggle (~Q[i]).
  - Bits are independent.
- Mode 01 (up): Q <= Q + 1 modulo 2^WIDTH. J, K and D are ignored.
- Mode 10 (down): Q <= Q - 1 modulo 2^WIDTH. J, K and D are ignored.
- Mode 11 (load): Q <= D. J and K are ignored.
- TC = En & ((Mode == 01 & Q == all-ones) | (Mode == 10 & Q == all-zeros)). It is 0 in Modes 00 and 11 and whenever En = 0.
- Wrap <= TC at each non-reset edge. It is high for exactly the one cycle following the wrapping edge: all-ones -> 0 going up, 0 -> all-ones going down.
- Wrap is 0 after loads and JK operations, even if Q passes through a wrap value.
- Mode changes take effect on the next edge with no pipeline delay. Latency from any input to Q is 1 cycle.
- Reset mid-count: Q = RESET_VAL on that edge and Wrap = 0, even if TC was 1 in the same cycle.
- Reset does not depend on En.
- WIDTH = 1: up and down both behave as toggle. TC is asserted when Q = 1 (up) or Q = 0 (down).
- No X propagation is allowed from unused inputs. J, K and D are don't-care outside their mode.

Test Plan (WIDTH = 4, RESET_VAL = 0 unless stated):
- Reset: hold Reset = 1 for one edge with arbitrary inputs -> Q = 0000, Qbar = 1111, Wrap = 0. Deasserting Reset between edges changes nothing until the next edge (synchronous check).
- JK truth table, Mode 00, En = 1, starting from Q = 0101:
  - J = 0000, K = 0000 -> Q = 0101.
  - J = 1010, K = 0000 -> Q = 1111.
  - J = 0000, K = 0011 -> Q = 1100.
  - J = 1111, K = 1111 -> Q = 0011.
- Up-count wrap, Mode 01 from 0000: 15 edges -> Q = 1111 with TC = 1. Next edge -> Q = 0000, and Wrap = 1 for exactly that one cycle.
- Down-count and load, Mode 11 with D = 0010, then Mode 10:
  - After the load, Q = 0010.
  - Q then steps 0001, 0000 (TC = 1), then 1111 with Wrap = 1.
- Enable and priority:
  - En = 0 in Mode 01 with Q = 1111 -> Q holds and TC = 0.
  - Reset = 1 together with En = 1, Mode 01, Q = 1111 -> Q = 0000 and Wrap = 0.
- Parameter sweep:
  - WIDTH = 1: Mode 01 toggles Q each edge, with Wrap pulsing every second cycle.
  - WIDTH = 8, RESET_VAL = 8'hA5: reset gives Q = A5 and Qbar = 5A.
